rsa_host_sequencer: RTL and testbench

RSA_HOST_SEQUENCER -- requirements
Module: rsa_host_sequencer

---
 rtl/rsa_host_sequencer.sv | 177 +++++++++++++++++
 tb/tb_rsa_host_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_host_sequencer.sv
// Host-side job sequencer for an RSA offload engine: runs READ, COMPUTE and WRITE command
// phases with per-wait-state timeout abort. All handshake strobes are registered.
module rsa_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] CMD_READ       = 32'h0,
  parameter logic [31:0] CMD_COMPUTE    = 32'h1,
  parameter logic [31:0] CMD_WRITE      = 32'h2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1023:0] operand,
  output logic          busy,
  output logic          result_valid,
  output logic [1023:0] result,
  output logic          error,
  output logic [1:0]    error_phase,
  output logic [31:0]   arm_to_fpga_cmd,
  output logic          arm_to_fpga_cmd_valid,
  input  logic          fpga_to_arm_done,
  output logic          fpga_to_arm_done_read,
  output logic          arm_to_fpga_data_valid,
  input  logic          arm_to_fpga_data_ready,
  output logic [1023:0] arm_to_fpga_data,
  input  logic          fpga_to_arm_data_valid,
  output logic          fpga_to_arm_data_ready,
  input  logic [1023:0] fpga_to_arm_data
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StSendCmd, StPushData, StPullData, StWaitDone, StAckDone, StWaitDoneClr
  } state_e;

  typedef enum logic [1:0] {PhRead = 2'd0, PhCompute = 2'd1, PhWrite = 2'd2} phase_e;

  state_e          r_state, w_state_d;
  phase_e          r_phase, w_phase_d;
  logic [CntW-1:0] r_cnt;
  logic [1023:0]   r_operand, r_result;
  logic [31:0]     r_cmd, w_cmd_d;
  logic [1:0]      r_error_phase;
  logic            r_busy, r_result_valid, r_error;
  logic            r_cmd_valid, r_data_valid, r_fdata_ready, r_done_read;
  logic            w_busy_d, w_cmd_valid_d, w_data_valid_d, w_fdata_ready_d, w_done_read_d;
  logic            w_timeout, w_abort, w_job_done, w_capture, w_accept;

  // The TIMEOUT_CYCLES-th cycle spent in a wait state without progress aborts.
  assign w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_d  = r_state;
    w_phase_d  = r_phase;
    w_abort    = 1'b0;
    w_job_done = 1'b0;
    w_capture  = 1'b0;
    w_accept   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StSendCmd;
          w_phase_d = PhRead;
          w_accept  = 1'b1;
        end
      end
      StSendCmd: begin
        unique case (r_phase)
          PhRead:    w_state_d = StPushData;
          PhCompute: w_state_d = StWaitDone;
          default:   w_state_d = StPullData;
        endcase
      end
      StPushData: begin
        if (arm_to_fpga_data_ready) w_state_d = StWaitDone;
        else if (w_timeout)         w_abort   = 1'b1;
      end
      StPullData: begin
        if (fpga_to_arm_data_valid) begin
          w_capture = 1'b1;
          w_state_d = StWaitDone;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      StWaitDone: begin
        if (fpga_to_arm_done) w_state_d = StAckDone;
        else if (w_timeout)   w_abort   = 1'b1;
      end
      StAckDone: w_state_d = StWaitDoneClr;
      StWaitDoneClr: begin
        if (!fpga_to_arm_done) begin
          unique case (r_phase)
            PhRead: begin
              w_phase_d = PhCompute;
              w_state_d = StSendCmd;
            end
            PhCompute: begin
              w_phase_d = PhWrite;
              w_state_d = StSendCmd;
            end
            default: begin
              w_state_d  = StIdle;
              w_job_done = 1'b1;
            end
          endcase
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_abort) w_state_d = StIdle;
  end

  // Strobes are decoded from the next state so they register in step with the state.
  always_comb begin
    w_busy_d         = (w_state_d != StIdle);
    w_cmd_valid_d    = (w_state_d == StSendCmd);
    w_data_valid_d   = (w_state_d == StPushData);
    w_fdata_ready_d  = (w_state_d == StPullData);
    w_done_read_d    = (w_state_d == StAckDone);
    w_cmd_d          = r_cmd;
    if (w_state_d == StSendCmd) begin
      w_cmd_d = (w_phase_d == PhRead)    ? CMD_READ    :
                (w_phase_d == PhCompute) ? CMD_COMPUTE : CMD_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_phase        <= PhRead;
      r_cnt          <= '0;
      r_operand      <= '0;
      r_result       <= '0;
      r_cmd          <= '0;
      r_error_phase  <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_cmd_valid    <= 1'b0;
      r_data_valid   <= 1'b0;
      r_fdata_ready  <= 1'b0;
      r_done_read    <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_phase        <= w_phase_d;
      if (w_state_d != r_state)             r_cnt <= '0;
      else if (r_cnt != CntW'(TIMEOUT_CYCLES)) r_cnt <= r_cnt + 1'b1;
      if (w_accept)  r_operand     <= operand;
      if (w_capture) r_result      <= fpga_to_arm_data;
      if (w_abort)   r_error_phase <= r_phase;
      r_cmd          <= w_cmd_d;
      r_busy         <= w_busy_d;
      r_result_valid <= w_job_done;
      r_error        <= w_abort;
      r_cmd_valid    <= w_cmd_valid_d;
      r_data_valid   <= w_data_valid_d;
      r_fdata_ready  <= w_fdata_ready_d;
      r_done_read    <= w_done_read_d;
    end
  end

  assign busy                   = r_busy;
  assign result_valid           = r_result_valid;
  assign result                 = r_result;
  assign error                  = r_error;
  assign error_phase            = r_error_phase;
  assign arm_to_fpga_cmd        = r_cmd;
  assign arm_to_fpga_cmd_valid  = r_cmd_valid;
  assign fpga_to_arm_done_read  = r_done_read;
  assign arm_to_fpga_data_valid = r_data_valid;
  assign arm_to_fpga_data       = r_operand;
  assign fpga_to_arm_data_ready = r_fdata_ready;

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Directed bench for rsa_host_sequencer with an FPGA responder model that XORs the
// top word with 32'hDEADBEEF on COMPUTE.
module tb_rsa_host_sequencer;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1023:0] operand;
  logic          busy, result_valid, error;
  logic [1023:0] result, arm_to_fpga_data, fpga_to_arm_data;
  logic [1:0]    error_phase;
  logic [31:0]   arm_to_fpga_cmd;
  logic          arm_to_fpga_cmd_valid, fpga_to_arm_done, fpga_to_arm_done_read;
  logic          arm_to_fpga_data_valid, arm_to_fpga_data_ready;
  logic          fpga_to_arm_data_valid, fpga_to_arm_data_ready;

  rsa_host_sequencer dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .operand                (operand),
    .busy                   (busy),
    .result_valid           (result_valid),
    .result                 (result),
    .error                  (error),
    .error_phase            (error_phase),
    .arm_to_fpga_cmd        (arm_to_fpga_cmd),
    .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
    .fpga_to_arm_done       (fpga_to_arm_done),
    .fpga_to_arm_done_read  (fpga_to_arm_done_read),
    .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
    .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
    .arm_to_fpga_data       (arm_to_fpga_data),
    .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
    .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
    .fpga_to_arm_data       (fpga_to_arm_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Responder configuration (written by the main sequence only).
  bit hold_ready_low = 1'b0;
  int hold_extra     = 0;

  // Responder state and monitors (written by the responder only).
  int            cyc = 0, fall_cyc = 0, hold_cnt = 0;
  int            n_rv = 0, n_err = 0, n_dv = 0, n_dr = 0, n_cmd = 0, n_gap = 0, n_bad = 0;
  logic [5:0]    cmd_hist = '0;
  logic [1023:0] mem = '0;

  int b_rv, b_err, b_dv, b_dr, b_cmd, b_gap, b_bad;

  // Responder acts on the falling edge, so its inputs are stable at the DUT's rising edge.
  initial begin
    fpga_to_arm_done       = 1'b0;
    arm_to_fpga_data_ready = 1'b0;
    fpga_to_arm_data_valid = 1'b0;
    fpga_to_arm_data       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        fpga_to_arm_done       = 1'b0;
        arm_to_fpga_data_ready = 1'b0;
        fpga_to_arm_data_valid = 1'b0;
        hold_cnt               = 0;
      end else begin
        if (result_valid)           n_rv++;
        if (error)                  n_err++;
        if (arm_to_fpga_data_valid) n_dv++;
        if (fpga_to_arm_done_read)  n_dr++;
        if (arm_to_fpga_cmd_valid) begin
          n_cmd++;
          cmd_hist = {cmd_hist[3:0], arm_to_fpga_cmd[1:0]};
          if (arm_to_fpga_cmd != 32'h0) begin
            n_gap++;
            if (fpga_to_arm_done || (cyc - fall_cyc) < 1) n_bad++;
          end
          if (arm_to_fpga_cmd == 32'h1) begin
            mem[1023:992]    = mem[1023:992] ^ 32'hDEADBEEF;
            fpga_to_arm_done = 1'b1;
          end
        end
        if (arm_to_fpga_data_valid && !arm_to_fpga_data_ready && !hold_ready_low) begin
          arm_to_fpga_data_ready = 1'b1;
          mem                    = arm_to_fpga_data;
        end else if (arm_to_fpga_data_ready && !arm_to_fpga_data_valid) begin
          arm_to_fpga_data_ready = 1'b0;
          fpga_to_arm_done       = 1'b1;
        end
        if (fpga_to_arm_data_ready && !fpga_to_arm_data_valid) begin
          fpga_to_arm_data_valid = 1'b1;
          fpga_to_arm_data       = mem;
        end else if (fpga_to_arm_data_valid && !fpga_to_arm_data_ready) begin
          fpga_to_arm_data_valid = 1'b0;
          fpga_to_arm_done       = 1'b1;
        end
        if (fpga_to_arm_done_read) begin
          if (hold_extra == 0) begin
            fpga_to_arm_done = 1'b0;
            fall_cyc         = cyc;
          end else begin
            hold_cnt = hold_extra;
          end
        end else if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) begin
            fpga_to_arm_done = 1'b0;
            fall_cyc         = cyc;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed top=%h low=%h expected top=%h low=%h", tag,
             obs[1023:992], obs[63:0], exp[1023:992], exp[63:0]);
    end
  endtask

  task automatic snap();
    b_rv = n_rv; b_err = n_err; b_dv = n_dv; b_dr = n_dr;
    b_cmd = n_cmd; b_gap = n_gap; b_bad = n_bad;
  endtask

  task automatic start_job(input logic [1023:0] op, output logic busy_next);
    @(negedge clk);
    start   = 1'b1;
    operand = op;
    @(negedge clk);
    start     = 1'b0;
    busy_next = busy;
  endtask

  // Waits (bounded) for result_valid or error, then lets the responder monitors settle.
  task automatic wait_end(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (result_valid || error) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic          b, ok;
  logic [1023:0] op, exp_res;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    operand = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_err_phase", error_phase, 0);
    chk("rst_cmd", arm_to_fpga_cmd, 0);
    chk("rst_strobes", {arm_to_fpga_cmd_valid, arm_to_fpga_data_valid,
                        fpga_to_arm_data_ready, fpga_to_arm_done_read,
                        result_valid, error}, 0);
    chk("rst_out_data", arm_to_fpga_data, 0);
    reset = 1'b0;

    // Job 1: operand 1 through READ/COMPUTE/WRITE.
    snap();
    op = 1024'h1;
    start_job(op, b);
    chk("j1_busy_next", b, 1);
    wait_end(ok);
    chk("j1_finished", ok, 1);
    exp_res = {32'hDEADBEEF, 992'h1};
    chk("j1_result", result, exp_res);
    chk("j1_rv_count", n_rv - b_rv, 1);
    chk("j1_cmd_seq", cmd_hist, 6'b00_01_10);
    chk("j1_cmd_count", n_cmd - b_cmd, 3);
    chk("j1_done_reads", n_dr - b_dr, 3);
    chk("j1_no_error", n_err - b_err, 0);
    chk("j1_busy_idle", busy, 0);
    chk("j1_cmd_held", arm_to_fpga_cmd, 32'h2);
    chk("j1_out_data", arm_to_fpga_data, op);

    // Job 2: top word DEADBEEF is cancelled by the responder.
    snap();
    op = {32'hDEADBEEF, 992'h12345};
    start_job(op, b);
    wait_end(ok);
    chk("j2_finished", ok, 1);
    exp_res = {32'h0, 992'h12345};
    chk("j2_result", result, exp_res);
    chk("j2_rv_count", n_rv - b_rv, 1);

    // Job 3: responder never accepts outbound data.
    snap();
    hold_ready_low = 1'b1;
    start_job(1024'h77, b);
    wait_end(ok);
    hold_ready_low = 1'b0;
    chk("to_finished", ok, 1);
    chk("to_err_pulses", n_err - b_err, 1);
    chk("to_dv_cycles", n_dv - b_dv, 1024);
    chk("to_err_phase", error_phase, 0);
    chk("to_busy", busy, 0);
    chk("to_error_low", error, 0);
    chk("to_dv_low", arm_to_fpga_data_valid, 0);
    chk("to_result_kept", result, exp_res);
    chk("to_no_rv", n_rv - b_rv, 0);

    // Job 4: a second start while busy is ignored.
    snap();
    start_job(1024'h2, b);
    repeat (3) @(negedge clk);
    start   = 1'b1;
    operand = 1024'h3;
    @(negedge clk);
    start = 1'b0;
    wait_end(ok);
    chk("rp_finished", ok, 1);
    exp_res = {32'hDEADBEEF, 992'h2};
    chk("rp_result", result, exp_res);
    chk("rp_rv_count", n_rv - b_rv, 1);
    chk("rp_cmd_count", n_cmd - b_cmd, 3);
    chk("rp_out_data", arm_to_fpga_data, 1024'h2);
    repeat (20) @(negedge clk);
    chk("rp_no_extra_job", n_cmd - b_cmd, 3);

    // Job 5: reset during PULL_DATA, then an immediate new job.
    start_job(1024'h7, b);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (fpga_to_arm_data_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mr_reached_pull", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_strobes", {arm_to_fpga_cmd_valid, arm_to_fpga_data_valid,
                       fpga_to_arm_data_ready, fpga_to_arm_done_read,
                       result_valid, error, busy}, 0);
    chk("mr_result", result, 0);
    chk("mr_cmd", arm_to_fpga_cmd, 0);
    chk("mr_out_data", arm_to_fpga_data, 0);
    snap();
    reset   = 1'b0;
    start   = 1'b1;
    operand = 1024'h9;
    @(negedge clk);
    start = 1'b0;
    chk("mr_first_cycle_start", busy, 1);
    wait_end(ok);
    chk("mr_finished", ok, 1);
    exp_res = {32'hDEADBEEF, 992'h9};
    chk("mr_result_new", result, exp_res);
    chk("mr_rv_count", n_rv - b_rv, 1);

    // Job 6: done held 5 extra cycles after each done_read.
    snap();
    hold_extra = 5;
    start_job(1024'h4, b);
    wait_end(ok);
    hold_extra = 0;
    chk("dh_finished", ok, 1);
    exp_res = {32'hDEADBEEF, 992'h4};
    chk("dh_result", result, exp_res);
    chk("dh_done_reads", n_dr - b_dr, 3);
    chk("dh_gaps_seen", n_gap - b_gap, 2);
    chk("dh_early_cmds", n_bad - b_bad, 0);
    chk("dh_err_phase_kept", error_phase, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
